// File: rtl/lifo_arbiter.sv
// ---------------------------------------------------------------------------
// lifo_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter and sequencer in front of one shared
//   LIFO stack. Each granted request is run as a fixed three-cycle
//   transaction:
//     IDLE  : pick a requester, capture its op, data and legality
//     ISSUE : one-cycle s_wr or s_rd strobe (legal operations only)
//     RESP  : one-cycle ack to the granted requester, err = rejected
//   A push while the stack is full, or a pop while it is empty, is rejected.
//   Rejected operations never touch the stack, so the tracked level stays
//   within 0 .. 2**W.
//
// Parameters:
//   B : data word width in bits
//   W : stack address bits (depth = 2**W); level is W+1 bits wide
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   reqN_valid/op/data     request from requester N (op: 0 = push, 1 = pop)
//   reqN_ack/err/rdata     registered completion pulse, reject flag, pop data
//   s_wr, s_rd, s_wdata    strobes and write data towards the stack
//   s_full, s_empty, s_top status and combinational top word from the stack
//   level                  number of words in the stack, tracked here
//   last_grant             index of the most recently granted requester
//
// Optional feature (macro LIFO_ARB_STATS_EN):
//   grant_cnt0, grant_cnt1, err_cnt : 8-bit saturating counters of grants
//   per requester and of rejected operations, all bumped in RESP.
// ---------------------------------------------------------------------------
module lifo_arbiter #(
  parameter int B = 3,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         req0_valid,
  input  logic         req0_op,
  input  logic [B-1:0] req0_data,
  output logic         req0_ack,
  output logic         req0_err,
  output logic [B-1:0] req0_rdata,

  input  logic         req1_valid,
  input  logic         req1_op,
  input  logic [B-1:0] req1_data,
  output logic         req1_ack,
  output logic         req1_err,
  output logic [B-1:0] req1_rdata,

  output logic         s_wr,
  output logic         s_rd,
  output logic [B-1:0] s_wdata,
  input  logic         s_full,
  input  logic         s_empty,
  input  logic [B-1:0] s_top,

  output logic [W:0]   level,
  output logic         last_grant
`ifdef LIFO_ARB_STATS_EN
  ,
  output logic [7:0]   grant_cnt0,
  output logic [7:0]   grant_cnt1,
  output logic [7:0]   err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [W:0] LVL_ONE = {{W{1'b0}}, 1'b1};

  state_e       state_q,      state_d;
  logic         sel_q,        sel_d;
  logic         op_q,         op_d;
  logic         legal_q,      legal_d;
  logic         last_grant_q, last_grant_d;
  logic [W:0]   level_q,      level_d;
  logic         s_wr_q,       s_wr_d;
  logic         s_rd_q,       s_rd_d;
  logic [B-1:0] s_wdata_q,    s_wdata_d;
  logic         ack0_q,       ack0_d;
  logic         ack1_q,       ack1_d;
  logic         err0_q,       err0_d;
  logic         err1_q,       err1_d;
  logic [B-1:0] rdata0_q,     rdata0_d;
  logic [B-1:0] rdata1_q,     rdata1_d;

  logic         any_valid_s;
  logic         pick_s;
  logic         pick_op_s;
  logic [B-1:0] pick_data_s;
  logic         pick_legal_s;
  logic [B-1:0] resp_data_s;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      pick_s = ~last_grant_q;
    end else if (req1_valid) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (pick_s) begin
      pick_op_s   = req1_op;
      pick_data_s = req1_data;
    end else begin
      pick_op_s   = req0_op;
      pick_data_s = req0_data;
    end
    // Legality is judged on the flags seen in IDLE; they have settled by then.
    pick_legal_s = pick_op_s ? ~s_empty : ~s_full;
  end

  // Word returned to the requester: the pre-pop top for a legal pop, else 0.
  always_comb begin
    if (legal_q && op_q) begin
      resp_data_s = s_top;
    end else begin
      resp_data_s = {B{1'b0}};
    end
  end

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    op_d         = op_q;
    legal_d      = legal_q;
    last_grant_d = last_grant_q;
    level_d      = level_q;
    s_wr_d       = 1'b0;
    s_rd_d       = 1'b0;
    s_wdata_d    = s_wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = err0_q;
    err1_d       = err1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          sel_d        = pick_s;
          op_d         = pick_op_s;
          legal_d      = pick_legal_s;
          last_grant_d = pick_s;
          state_d      = ST_ISSUE;
          // Strobes are registered here so that they are high during ISSUE.
          if (pick_legal_s && !pick_op_s) begin
            s_wr_d    = 1'b1;
            s_wdata_d = pick_data_s;
          end else if (pick_legal_s && pick_op_s) begin
            s_rd_d = 1'b1;
          end else begin
            s_wr_d = 1'b0;
            s_rd_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (legal_q && !op_q) begin
          level_d = level_q + LVL_ONE;
        end else if (legal_q && op_q) begin
          level_d = level_q - LVL_ONE;
        end else begin
          level_d = level_q;
        end
        // Response registers load at the end of ISSUE, so the ack is seen
        // in RESP together with its err and rdata.
        if (sel_q) begin
          ack1_d   = 1'b1;
          err1_d   = ~legal_q;
          rdata1_d = resp_data_s;
        end else begin
          ack0_d   = 1'b1;
          err0_d   = ~legal_q;
          rdata0_d = resp_data_s;
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      op_q         <= 1'b0;
      legal_q      <= 1'b0;
      last_grant_q <= 1'b1;
      level_q      <= {(W+1){1'b0}};
      s_wr_q       <= 1'b0;
      s_rd_q       <= 1'b0;
      s_wdata_q    <= {B{1'b0}};
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= {B{1'b0}};
      rdata1_q     <= {B{1'b0}};
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      op_q         <= op_d;
      legal_q      <= legal_d;
      last_grant_q <= last_grant_d;
      level_q      <= level_d;
      s_wr_q       <= s_wr_d;
      s_rd_q       <= s_rd_d;
      s_wdata_q    <= s_wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign req0_ack   = ack0_q;
  assign req0_err   = err0_q;
  assign req0_rdata = rdata0_q;
  assign req1_ack   = ack1_q;
  assign req1_err   = err1_q;
  assign req1_rdata = rdata1_q;
  assign s_wr       = s_wr_q;
  assign s_rd       = s_rd_q;
  assign s_wdata    = s_wdata_q;
  assign level      = level_q;
  assign last_grant = last_grant_q;

`ifdef LIFO_ARB_STATS_EN
  logic [7:0] grant_cnt0_q, grant_cnt0_d;
  logic [7:0] grant_cnt1_q, grant_cnt1_d;
  logic [7:0] err_cnt_q,    err_cnt_d;

  // Saturating statistics, bumped once per completed transaction in RESP.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    err_cnt_d    = err_cnt_q;
    if (state_q == ST_RESP) begin
      if (!sel_q && (grant_cnt0_q != 8'hFF)) begin
        grant_cnt0_d = grant_cnt0_q + 8'd1;
      end else if (sel_q && (grant_cnt1_q != 8'hFF)) begin
        grant_cnt1_d = grant_cnt1_q + 8'd1;
      end else begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
      end
      if (!legal_q && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      grant_cnt0_d = grant_cnt0_q;
      grant_cnt1_d = grant_cnt1_q;
      err_cnt_d    = err_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_q <= 8'd0;
      grant_cnt1_q <= 8'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_lifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lifo_arbiter
//
// Self-checking bench for lifo_arbiter. A small behavioural stack sits on the
// stack side of the DUT. A transaction-level reference model (a queue for
// the stack contents, an integer for the last winner) predicts the winner,
// the strobes, the ack/err/rdata and the level of every transaction.
// Directed cases come first, followed by a randomized stretch.
// ---------------------------------------------------------------------------
module tb_lifo_arbiter;

  localparam int B     = 3;
  localparam int W     = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_op, req0_ack, req0_err;
  logic [B-1:0] req0_data, req0_rdata;
  logic         req1_valid, req1_op, req1_ack, req1_err;
  logic [B-1:0] req1_data, req1_rdata;
  logic         s_wr, s_rd, s_full, s_empty;
  logic [B-1:0] s_wdata, s_top;
  logic [W:0]   level;
  logic         last_grant;
`ifdef LIFO_ARB_STATS_EN
  logic [7:0]   grant_cnt0, grant_cnt1, err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lifo_arbiter #(.B(B), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data),
    .req0_ack(req0_ack), .req0_err(req0_err), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data),
    .req1_ack(req1_ack), .req1_err(req1_err), .req1_rdata(req1_rdata),
    .s_wr(s_wr), .s_rd(s_rd), .s_wdata(s_wdata),
    .s_full(s_full), .s_empty(s_empty), .s_top(s_top),
    .level(level), .last_grant(last_grant)
`ifdef LIFO_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt)
`endif
  );

  // Behavioural stack driven by the DUT strobes.
  logic [B-1:0] smem [DEPTH];
  int           scnt;
  always @(posedge clk) begin
    if (reset) begin
      scnt <= 0;
    end else if (s_wr && scnt < DEPTH) begin
      smem[scnt] <= s_wdata;
      scnt       <= scnt + 1;
    end else if (s_rd && scnt > 0) begin
      scnt <= scnt - 1;
    end
  end
  assign s_full  = (scnt == DEPTH);
  assign s_empty = (scnt == 0);
  assign s_top   = (scnt > 0) ? smem[(scnt > 0) ? scnt - 1 : 0] : '0;

  // Reference model state.
  logic [B-1:0] mq [$];
  int           m_lg;
  logic [B-1:0] m_rdata [2];
  logic         m_err [2];
  int           m_gc [2];
  int           m_ec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic o, input logic [B-1:0] d);
    if (r == 0) begin
      req0_valid = v; req0_op = o; req0_data = d;
    end else begin
      req1_valid = v; req1_op = o; req1_data = d;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_lg = 1;
    m_rdata[0] = '0; m_rdata[1] = '0;
    m_err[0] = 1'b0; m_err[1] = 1'b0;
    m_gc[0] = 0; m_gc[1] = 0; m_ec = 0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef LIFO_ARB_STATS_EN
    chk({tag, "_gc0"}, grant_cnt0, m_gc[0]);
    chk({tag, "_gc1"}, grant_cnt1, m_gc[1]);
    chk({tag, "_ec"},  err_cnt,    m_ec);
`endif
  endtask

  // Holds reset for two edges; returns just after an edge with the DUT idle.
  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_last_grant", last_grant, 1);
    chk("rst_ack0", req0_ack, 0);
    chk("rst_ack1", req1_ack, 0);
    chk("rst_wr", s_wr, 0);
    chk("rst_rd", s_rd, 0);
    chk("rst_rdata0", req0_rdata, 0);
    chk("rst_err1", req1_err, 0);
    chk("rst_wdata", s_wdata, 0);
    chk_stats("rst");
    @(posedge clk);
    #1;
  endtask

  // One arbitrated transaction. Called just after an edge while the DUT is
  // idle and the requests of this cycle are already applied; returns just
  // after the edge that ends the response cycle.
  task automatic txn(output int w);
    logic         op;
    logic [B-1:0] d;
    logic [B-1:0] exp_rd;
    logic         legal;
    if (req0_valid && req1_valid) w = (m_lg == 0) ? 1 : 0;
    else if (req1_valid)          w = 1;
    else                          w = 0;
    op    = (w == 1) ? req1_op   : req0_op;
    d     = (w == 1) ? req1_data : req0_data;
    legal = op ? (mq.size() > 0) : (mq.size() < DEPTH);

    @(negedge clk);
    chk("idle_ack0", req0_ack, 0);
    chk("idle_ack1", req1_ack, 0);
    chk("idle_wr", s_wr, 0);
    chk("idle_rd", s_rd, 0);

    @(negedge clk);
    chk("issue_wr", s_wr, legal && !op);
    chk("issue_rd", s_rd, legal && op);
    if (legal && !op) chk("issue_wdata", s_wdata, d);
    chk("issue_grant", last_grant, w);
    chk("issue_ack0", req0_ack, 0);
    chk("issue_ack1", req1_ack, 0);

    exp_rd = '0;
    if (legal) begin
      if (op) exp_rd = mq.pop_back();
      else    mq.push_back(d);
    end
    m_lg       = w;
    m_rdata[w] = exp_rd;
    m_err[w]   = !legal;
    if (m_gc[w] < 255) m_gc[w]++;
    if (!legal && m_ec < 255) m_ec++;

    @(negedge clk);
    chk("resp_ack0", req0_ack, w == 0);
    chk("resp_ack1", req1_ack, w == 1);
    chk("resp_err0", req0_err, m_err[0]);
    chk("resp_err1", req1_err, m_err[1]);
    chk("resp_rdata0", req0_rdata, m_rdata[0]);
    chk("resp_rdata1", req1_rdata, m_rdata[1]);
    chk("resp_level", level, mq.size());
    chk("resp_wr", s_wr, 0);
    chk("resp_rd", s_rd, 0);

    @(posedge clk);
    #1;
    chk_stats("txn");
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);

    // Single push from requester 0.
    do_reset();
    set_req(0, 1'b1, 1'b0, 3'd5);
    txn(w);
    set_req(0, 1'b0, 1'b0, '0);
    chk("single_winner", w, 0);
    chk("single_level", level, 1);
    chk("single_err", req0_err, 0);

    // Fill from requester 1, then overflow.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_req(1, 1'b1, 1'b0, B'(i));
      txn(w);
    end
    chk("fill_level", level, 4);
    chk("fill_full", s_full, 1);
    set_req(1, 1'b1, 1'b0, 3'd5);
    txn(w);
    set_req(1, 1'b0, 1'b0, '0);
    chk("ovf_err", req1_err, 1);
    chk("ovf_level", level, 4);

    // LIFO order and underflow on requester 0.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_req(0, 1'b1, 1'b0, B'(i));
      txn(w);
    end
    for (int i = 3; i >= 1; i--) begin
      set_req(0, 1'b1, 1'b1, '0);
      txn(w);
      chk("lifo_rdata", req0_rdata, i);
    end
    chk("lifo_level", level, 0);
    set_req(0, 1'b1, 1'b1, '0);
    txn(w);
    set_req(0, 1'b0, 1'b0, '0);
    chk("udf_err", req0_err, 1);
    chk("udf_rdata", req0_rdata, 0);

    // Contention straight after reset: requester 0 first, then 1.
    do_reset();
    set_req(0, 1'b1, 1'b0, 3'd6);
    set_req(1, 1'b1, 1'b0, 3'd7);
    txn(w);
    chk("cont_first", w, 0);
    set_req(0, 1'b0, 1'b0, '0);
    txn(w);
    chk("cont_second", w, 1);
    chk("cont_last_grant", last_grant, 1);
    set_req(1, 1'b0, 1'b0, '0);

    // Reset while a push is in ISSUE.
    do_reset();
    set_req(0, 1'b1, 1'b0, 3'd4);
    set_req(1, 1'b1, 1'b0, 3'd3);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rmid_issue_wr", s_wr, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    model_reset();
    @(negedge clk);
    chk("rmid_ack0_a", req0_ack, 0);
    chk("rmid_ack1_a", req1_ack, 0);
    chk("rmid_level", level, 0);
    chk("rmid_last_grant", last_grant, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rmid_ack0_b", req0_ack, 0);
    @(posedge clk);
    #1;
    set_req(1, 1'b1, 1'b0, 3'd2);
    txn(w);
    set_req(1, 1'b0, 1'b0, '0);
    chk("rmid_after_winner", w, 1);
    chk("rmid_after_level", level, 1);

    // Randomized stretch against the reference model.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      if (!req0_valid && ($urandom % 3 != 0))
        set_req(0, 1'b1, 1'($urandom), B'($urandom));
      if (!req1_valid && ($urandom % 3 != 0))
        set_req(1, 1'b1, 1'($urandom), B'($urandom));
      if (!req0_valid && !req1_valid) begin
        @(negedge clk);
        chk("rand_idle_ack0", req0_ack, 0);
        chk("rand_idle_ack1", req1_ack, 0);
        @(posedge clk);
        #1;
      end else begin
        txn(w);
        set_req(w, 1'b0, 1'b0, '0);
      end
    end
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);

`ifdef LIFO_ARB_STATS_EN
    // Statistics: 3 grants to 0, 2 to 1, one rejected pop.
    do_reset();
    set_req(0, 1'b1, 1'b0, 3'd1); txn(w);
    set_req(0, 1'b1, 1'b0, 3'd2); txn(w);
    set_req(0, 1'b1, 1'b1, '0);   txn(w);
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b1, 1'b1, '0);   txn(w);
    set_req(1, 1'b1, 1'b1, '0);   txn(w);
    set_req(1, 1'b0, 1'b0, '0);
    chk("stats_gc0", grant_cnt0, 3);
    chk("stats_gc1", grant_cnt1, 2);
    chk("stats_ec", err_cnt, 1);

    // Saturation after 300 grants to requester 0.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      set_req(0, 1'b1, 1'(i % 2), B'(i));
      txn(w);
    end
    set_req(0, 1'b0, 1'b0, '0);
    chk("stats_sat_gc0", grant_cnt0, 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
